uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NumRequesters, default 4, giving the number of byte producers sharing one UART transmitter (legal range 2..8).
REQ-002 The block SHALL have parameter IdleTimeout, default 16, giving the number of cycles a granted requester may stall mid-burst before its grant is revoked (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port req_valid, input, NumRequesters bits: per-requester byte valid.
REQ-006 The block SHALL have port req_byte, input, NumRequesters*8 bits: per-requester byte, with requester k in bits [8k+7:8k].
REQ-007 The block SHALL have port req_last, input, NumRequesters bits: marks the final byte of a requester's burst.
REQ-008 The block SHALL have port req_ready, output, NumRequesters bits: per-requester byte accepted.
REQ-009 The block SHALL have port tx_byte, output, 8 bits: byte to the UART transmitter.
REQ-010 The block SHALL have port tx_byte_valid, output, 1 bit: tx_byte is valid.
REQ-011 The block SHALL have port tx_byte_ready, input, 1 bit: the transmitter accepts the byte.
REQ-012 The block SHALL have port grant_id, output, clog2(NumRequesters) bits: index of the current grant holder.
REQ-013 The block SHALL have port busy, output, 1 bit: asserted when a grant is held.

Function
REQ-014 The block SHALL implement the states IDLE and LOCKED.
REQ-015 In IDLE, if any req_valid bit is set, the block SHALL grant the first set bit searching round-robin from last_grant+1 (wrapping modulo NumRequesters), register grant_id, and enter LOCKED on the next cycle; arbitration latency is therefore 1 cycle.
REQ-016 In IDLE, tx_byte_valid, all req_ready bits and busy SHALL be 0.
REQ-017 In LOCKED with grant g, the block SHALL drive tx_byte_valid=req_valid[g], tx_byte=req_byte[g] and req_ready[g]=tx_byte_ready; all other req_ready bits SHALL be 0, and busy SHALL be 1.
REQ-018 A transfer SHALL occur on a cycle where req_valid[g] and tx_byte_ready are both 1.
REQ-019 A transfer with req_last[g]=1 SHALL return the block to IDLE on the next cycle and set last_grant to g.
REQ-020 The block SHALL hold the grant across transfers with req_last=0; no other requester may interleave bytes within a burst.
REQ-021 In LOCKED, a stall counter SHALL increment on each cycle with req_valid[g]=0 and clear on any cycle with req_valid[g]=1.
REQ-022 When the stall counter reaches IdleTimeout, the block SHALL return to IDLE, set last_grant to g, and perform no transfer on that cycle.
REQ-023 The block SHALL not let tx_byte_ready=1 while tx_byte_valid=0 cause any state change.
REQ-024 When a requester becomes valid on the same cycle the current burst ends, it SHALL be considered in the IDLE cycle that follows, never in the same cycle.
REQ-025 The block SHALL never change tx_byte or grant_id while tx_byte_valid=1 and tx_byte_ready=0, provided the requester holds its byte stable.
REQ-026 Single-byte bursts (req_last=1 on the first byte) SHALL take 1 arbitration cycle plus the transfer cycle.

Reset
REQ-027 While rst_n=0, the block SHALL asynchronously force state=IDLE, grant_id=0, last_grant=NumRequesters-1 (so requester 0 wins first), stall counter=0, tx_byte_valid=0, req_ready=0 and busy=0.
REQ-028 Reset asserted mid-burst SHALL drop the burst without a transfer; after release, arbitration SHALL restart from requester 0.

Structure
REQ-029 A shared package SHALL hold the state enum, the byte width constant (8) and the clog2-derived grant width function.
REQ-030 The round-robin priority picker SHALL be one sub-module, rr_pick, that is purely combinational, with inputs req and last and output idx/found.

Verification
REQ-031 After reset, requesters 0 and 2 simultaneously send single bytes 0x59 and 0x58 with tx_byte_ready=1 -> the bench SHALL check tx sees 0x59 then 0x58, with grant_id 0 then 2.
REQ-032 Requester 1 sends a 4-byte burst 0x59,0x58,0x57,0x56 (last on 0x56) while requester 3 is valid throughout -> the bench SHALL check all four bytes appear contiguously before any requester-3 byte.
REQ-033 tx_byte_ready is held 0 for 10 cycles with a grant held -> the bench SHALL check tx_byte and grant_id are stable and req_ready[g]=0 throughout.
REQ-034 The granted requester drops valid mid-burst for IdleTimeout=16 cycles -> the bench SHALL check busy falls after 16 cycles and the next pending requester is granted.
REQ-035 All four requesters stay valid with single-byte bursts -> the bench SHALL check the grant order is 0,1,2,3,0.
REQ-036 rst_n is pulsed low during the second byte of a burst -> the bench SHALL check outputs are 0 immediately (asynchronously) and requester 0 wins first after release.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the arbiter state encoding, the byte width and the grant index width helper.
package uart_tx_arbiter_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    function automatic int grant_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set req bit searching upward from last+1, wrapping.
// Purely combinational (zero latency); no backpressure of its own.
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int N    = 4,
    localparam int IdxW = grant_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] last,
    output logic [IdxW-1:0] idx,
    output logic            found
);

    logic [IdxW-1:0] w_cand;

    // Walk the search order backwards so the earliest candidate is the final writer.
    always_comb begin
        idx    = '0;
        found  = 1'b0;
        w_cand = '0;
        for (int i = N; i >= 1; i--) begin
            w_cand = IdxW'((int'(last) + i) % N);
            if (req[w_cand]) begin
                idx   = w_cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Burst-locked round-robin arbiter feeding one UART transmitter; 1-cycle grant latency.
// Backpressure: tx_byte_ready passes straight to the granted req_ready; grant revoked after IdleTimeout stalled cycles.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int NumRequesters = 4,
    parameter  int IdleTimeout   = 16,
    localparam int GrantW        = grant_width(NumRequesters)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NumRequesters-1:0]        req_valid,
    input  logic [NumRequesters*BYTE_W-1:0] req_byte,
    input  logic [NumRequesters-1:0]        req_last,
    output logic [NumRequesters-1:0]        req_ready,
    output logic [BYTE_W-1:0]               tx_byte,
    output logic                            tx_byte_valid,
    input  logic                            tx_byte_ready,
    output logic [GrantW-1:0]               grant_id,
    output logic                            busy
);

    localparam logic [GrantW-1:0] LastGrantInit = GrantW'(NumRequesters - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [GrantW-1:0] r_grant;
    logic [GrantW-1:0] r_last_grant;
    logic [7:0]        r_stall;
    logic [8:0]        w_stall_inc;
    logic [GrantW-1:0] w_pick_idx;
    logic              w_pick_found;
    logic [BYTE_W-1:0] w_bytes [NumRequesters];
    logic              w_g_valid;
    logic              w_g_last;
    logic              w_xfer;
    logic              w_burst_end;
    logic              w_timeout;

    for (genvar k = 0; k < NumRequesters; k++) begin : g_unpack
        assign w_bytes[k] = req_byte[k*BYTE_W +: BYTE_W];
    end

    rr_pick #(
        .N (NumRequesters)
    ) u_rr_pick (
        .req   (req_valid),
        .last  (r_last_grant),
        .idx   (w_pick_idx),
        .found (w_pick_found)
    );

    assign w_g_valid   = req_valid[r_grant];
    assign w_g_last    = req_last[r_grant];
    assign w_xfer      = (r_state == ST_LOCKED) && w_g_valid && tx_byte_ready;
    assign w_burst_end = w_xfer && w_g_last;
    assign w_stall_inc = {1'b0, r_stall} + 9'd1;
    // Timeout fires on the stalled cycle that brings the count up to IdleTimeout.
    assign w_timeout   = (r_state == ST_LOCKED) && !w_g_valid &&
                         (w_stall_inc == 9'(IdleTimeout));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_pick_found) w_state_nxt = ST_LOCKED;
            ST_LOCKED: if (w_burst_end || w_timeout) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        tx_byte_valid = 1'b0;
        tx_byte       = '0;
        req_ready     = '0;
        if (r_state == ST_LOCKED) begin
            busy               = 1'b1;
            tx_byte_valid      = w_g_valid;
            tx_byte            = w_bytes[r_grant];
            req_ready[r_grant] = tx_byte_ready;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant      <= '0;
            r_last_grant <= LastGrantInit;
            r_stall      <= '0;
        end else if (r_state == ST_IDLE) begin
            r_stall <= '0;
            if (w_pick_found) begin
                r_grant <= w_pick_idx;
            end
        end else if (w_burst_end || w_timeout) begin
            r_last_grant <= r_grant;
            r_stall      <= '0;
        end else if (w_g_valid) begin
            r_stall <= '0;
        end else begin
            r_stall <= w_stall_inc[7:0];
        end
    end

    assign grant_id = r_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, per-cycle reference model, directed scenarios.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    typedef struct {
        logic [7:0] b;
        logic       l;
        int         gap;
    } item_t;

    typedef struct {
        int         g;
        logic [7:0] b;
    } obs_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_byte;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_byte;
    logic           tx_byte_valid;
    logic           tx_byte_ready;
    logic [1:0]     grant_id;
    logic           busy;

    uart_tx_arbiter #(
        .NumRequesters (N),
        .IdleTimeout   (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_byte      (req_byte),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_byte       (tx_byte),
        .tx_byte_valid (tx_byte_valid),
        .tx_byte_ready (tx_byte_ready),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    item_t        q [N][$];
    obs_t         obs [$];
    logic [N-1:0] acc = '0;
    int           n_chk  = 0;
    int           n_pass = 0;
    int           m_holder = -1;
    int           m_lastg  = N - 1;
    int           m_stall  = 0;
    logic         e_txv;
    logic [N-1:0] e_rdy;
    int           cnt;

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int rr_first(input logic [N-1:0] v, input int from);
        for (int i = 1; i <= N; i++) begin
            if (v[(from + i) % N]) return (from + i) % N;
        end
        return -1;
    endfunction

    // Reference model: who holds the grant, who was served last, how long the holder has stalled.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_busy", busy, 0);
                chk("rst_tx_valid", tx_byte_valid, 0);
                chk("rst_req_ready", req_ready, 0);
                chk("rst_grant_id", grant_id, 0);
                m_holder = -1;
                m_lastg  = N - 1;
                m_stall  = 0;
                acc      = '0;
            end else begin
                e_rdy = '0;
                e_txv = 1'b0;
                if (m_holder >= 0) begin
                    e_txv           = req_valid[m_holder];
                    e_rdy[m_holder] = tx_byte_ready;
                end
                chk("busy", busy, m_holder >= 0);
                chk("tx_valid", tx_byte_valid, e_txv);
                chk("req_ready", req_ready, e_rdy);
                if (m_holder >= 0) chk("grant_id", grant_id, m_holder);
                if (e_txv) chk("tx_byte", tx_byte, req_byte[m_holder*8 +: 8]);
                if (tx_byte_valid && tx_byte_ready)
                    obs.push_back('{g: int'(grant_id), b: tx_byte});
                acc = req_valid & req_ready;
                if (m_holder < 0) begin
                    m_holder = rr_first(req_valid, m_lastg);
                    m_stall  = 0;
                end else if (req_valid[m_holder]) begin
                    m_stall = 0;
                    if (tx_byte_ready && req_last[m_holder]) begin
                        m_lastg  = m_holder;
                        m_holder = -1;
                    end
                end else begin
                    m_stall++;
                    if (m_stall == TO) begin
                        m_lastg  = m_holder;
                        m_holder = -1;
                        m_stall  = 0;
                    end
                end
            end
        end
    end

    // Requester drivers: present queue heads, pop on handshake, honour idle gaps.
    initial begin
        item_t it;
        req_valid = '0;
        req_byte  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (acc[k] && q[k].size() > 0) void'(q[k].pop_front());
                if (q[k].size() == 0) begin
                    req_valid[k] = 1'b0;
                end else if (q[k][0].gap > 0) begin
                    it = q[k].pop_front();
                    it.gap--;
                    q[k].push_front(it);
                    req_valid[k] = 1'b0;
                end else begin
                    req_valid[k]       = 1'b1;
                    req_byte[k*8 +: 8] = q[k][0].b;
                    req_last[k]        = q[k][0].l;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic push(input int k, input logic [7:0] b, input logic l, input int gap);
        item_t it;
        it.b   = b;
        it.l   = l;
        it.gap = gap;
        q[k].push_back(it);
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = !busy && (req_valid == '0);
            for (int k = 0; k < N; k++) if (q[k].size() != 0) ok = 1'b0;
        end
        chk(name, ok, 1);
    endtask

    task automatic wait_grant(input string name, input int k, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = busy && (int'(grant_id) == k);
        end
        chk(name, ok, 1);
    endtask

    task automatic wait_obs(input string name, input int n, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = (obs.size() >= n);
        end
        chk(name, ok, 1);
    endtask

    task automatic check_obs(input string name, input int i, input int g, input logic [7:0] b);
        if (i < obs.size()) begin
            chk({name, "_grant"}, obs[i].g, g);
            chk({name, "_byte"}, obs[i].b, b);
        end else begin
            chk({name, "_missing"}, obs.size(), i + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        tx_byte_ready = 1'b0;
        repeat (3) tick();
        chk("reset_busy", busy, 0);
        chk("reset_grant_id", grant_id, 0);
        rst_n = 1'b1;

        // Simultaneous single bytes from 0 and 2: 0 first after reset.
        tx_byte_ready = 1'b1;
        obs.delete();
        push(0, 8'h59, 1'b1, 0);
        push(2, 8'h58, 1'b1, 0);
        wait_idle("t1_drain", 50);
        chk("t1_count", obs.size(), 2);
        check_obs("t1_0", 0, 0, 8'h59);
        check_obs("t1_1", 1, 2, 8'h58);

        // Four-byte burst from 1 with 3 pending: burst must not be interleaved.
        obs.delete();
        push(1, 8'h59, 1'b0, 0);
        push(1, 8'h58, 1'b0, 0);
        push(1, 8'h57, 1'b0, 0);
        push(1, 8'h56, 1'b1, 0);
        wait_grant("t2_grant1", 1, 20);
        push(3, 8'hA3, 1'b1, 0);
        wait_idle("t2_drain", 50);
        chk("t2_count", obs.size(), 5);
        check_obs("t2_0", 0, 1, 8'h59);
        check_obs("t2_1", 1, 1, 8'h58);
        check_obs("t2_2", 2, 1, 8'h57);
        check_obs("t2_3", 3, 1, 8'h56);
        check_obs("t2_4", 4, 3, 8'hA3);

        // Transmitter backpressure for 10 cycles while requester 0 holds the grant.
        obs.delete();
        tx_byte_ready = 1'b0;
        push(0, 8'h11, 1'b1, 0);
        wait_grant("t3_grant0", 0, 20);
        for (int i = 0; i < 10; i++) begin
            chk("t3_tx_byte", tx_byte, 8'h11);
            chk("t3_grant_id", grant_id, 0);
            chk("t3_req_ready", req_ready, 0);
            chk("t3_tx_valid", tx_byte_valid, 1);
            tick();
        end
        tx_byte_ready = 1'b1;
        wait_idle("t3_drain", 50);
        chk("t3_count", obs.size(), 1);
        check_obs("t3_0", 0, 0, 8'h11);

        // Holder 2 goes silent mid-burst: grant revoked after 16 cycles, 3 served next.
        obs.delete();
        push(2, 8'h21, 1'b0, 0);
        push(2, 8'h22, 1'b1, 20);
        push(3, 8'h31, 1'b1, 0);
        wait_obs("t4_first", 1, 50);
        cnt = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            cnt++;
            tick();
        end
        chk("t4_stall_len", cnt, TO);
        wait_grant("t4_grant3", 3, 10);
        wait_idle("t4_drain", 100);
        chk("t4_count", obs.size(), 3);
        check_obs("t4_0", 0, 2, 8'h21);
        check_obs("t4_1", 1, 3, 8'h31);
        check_obs("t4_2", 2, 2, 8'h22);

        // Reset pulsed during the second byte of a burst from 3.
        obs.delete();
        push(3, 8'h41, 1'b0, 0);
        push(3, 8'h42, 1'b0, 0);
        push(3, 8'h43, 1'b1, 0);
        wait_obs("t5_first", 1, 50);
        chk("t5_pre_tx_byte", tx_byte, 8'h42);
        chk("t5_pre_tx_valid", tx_byte_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_busy", busy, 0);
        chk("t5_async_tx_valid", tx_byte_valid, 0);
        chk("t5_async_req_ready", req_ready, 0);
        chk("t5_async_grant_id", grant_id, 0);
        q[3].delete();
        obs.delete();
        push(0, 8'h50, 1'b1, 0);
        push(1, 8'h51, 1'b1, 0);
        push(3, 8'h53, 1'b1, 0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_idle("t5_drain", 100);
        chk("t5_count", obs.size(), 3);
        check_obs("t5_0", 0, 0, 8'h50);
        check_obs("t5_1", 1, 1, 8'h51);
        check_obs("t5_2", 2, 3, 8'h53);

        // All four contending with single-byte bursts: rotation 0,1,2,3,0.
        obs.delete();
        push(0, 8'h60, 1'b1, 0);
        push(0, 8'h64, 1'b1, 0);
        push(1, 8'h61, 1'b1, 0);
        push(2, 8'h62, 1'b1, 0);
        push(3, 8'h63, 1'b1, 0);
        wait_idle("t6_drain", 100);
        chk("t6_count", obs.size(), 5);
        check_obs("t6_0", 0, 0, 8'h60);
        check_obs("t6_1", 1, 1, 8'h61);
        check_obs("t6_2", 2, 2, 8'h62);
        check_obs("t6_3", 3, 3, 8'h63);
        check_obs("t6_4", 4, 0, 8'h64);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
